// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - single-entry ALU issue register with MEM/WB operand forwarding
// Optional feature macro: ALU_ISSUE_SNOOP_EN (refresh held operands from the forwarding buses while stalled)
module alu_issue_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_alu_op,
  input  logic [RADDR_W-1:0] in_rs1,
  input  logic [RADDR_W-1:0] in_rs2,
  input  logic [XLEN-1:0]    in_rs1_data,
  input  logic [XLEN-1:0]    in_rs2_data,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [XLEN-1:0]    in_pc,
  input  logic               in_use_imm,
  input  logic               in_use_pc,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_reg_write,
  input  logic               fwd_mem_valid,
  input  logic [RADDR_W-1:0] fwd_mem_rd,
  input  logic [XLEN-1:0]    fwd_mem_data,
  input  logic               fwd_wb_valid,
  input  logic [RADDR_W-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0]    fwd_wb_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_alu_op,
  output logic [XLEN-1:0]    out_src_a,
  output logic [XLEN-1:0]    out_src_b,
  output logic [XLEN-1:0]    out_store_data,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_reg_write,
  output logic [15:0]        stall_cycles
);

  logic               valid;
  logic [2:0]         alu_op;
  logic [XLEN-1:0]    rs1_val;
  logic [XLEN-1:0]    rs2_val;
  logic [XLEN-1:0]    imm;
  logic [XLEN-1:0]    pc;
  logic               use_imm;
  logic               use_pc;
  logic [RADDR_W-1:0] rd;
  logic               reg_write;

  logic               capture;
  logic               stall_inc;
  logic [XLEN-1:0]    cap_rs1_val;
  logic [XLEN-1:0]    cap_rs2_val;

  // MEM bus wins over WB because it carries the younger result.
  function automatic logic [XLEN-1:0] resolve(
    input logic [RADDR_W-1:0] r,
    input logic [XLEN-1:0]    d,
    input logic               mem_v,
    input logic [RADDR_W-1:0] mem_r,
    input logic [XLEN-1:0]    mem_d,
    input logic               wb_v,
    input logic [RADDR_W-1:0] wb_r,
    input logic [XLEN-1:0]    wb_d
  );
    logic [XLEN-1:0] res;
    if (r == '0)
      res = '0;
    else if (mem_v && mem_r == r)
      res = mem_d;
    else if (wb_v && wb_r == r)
      res = wb_d;
    else
      res = d;
    return res;
  endfunction

  assign in_ready  = !valid || out_ready || flush || rst;
  assign capture   = in_valid && in_ready && !flush;
  assign stall_inc = valid && !out_ready && !flush;

  assign cap_rs1_val = resolve(in_rs1, in_rs1_data, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                               fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
  assign cap_rs2_val = resolve(in_rs2, in_rs2_data, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                               fwd_wb_valid, fwd_wb_rd, fwd_wb_data);

`ifdef ALU_ISSUE_SNOOP_EN
  logic [RADDR_W-1:0] rs1;
  logic [RADDR_W-1:0] rs2;
  logic [XLEN-1:0]    hold_rs1_val;
  logic [XLEN-1:0]    hold_rs2_val;

  assign hold_rs1_val = resolve(rs1, rs1_val, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                                fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
  assign hold_rs2_val = resolve(rs2, rs2_val, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                                fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= 1'b0;
      alu_op    <= 3'b000;
      rs1_val   <= '0;
      rs2_val   <= '0;
      imm       <= '0;
      pc        <= '0;
      use_imm   <= 1'b0;
      use_pc    <= 1'b0;
      rd        <= '0;
      reg_write <= 1'b0;
`ifdef ALU_ISSUE_SNOOP_EN
      rs1       <= '0;
      rs2       <= '0;
`endif
    end else if (flush) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid     <= 1'b1;
      alu_op    <= in_alu_op;
      rs1_val   <= cap_rs1_val;
      rs2_val   <= cap_rs2_val;
      imm       <= in_imm;
      pc        <= in_pc;
      use_imm   <= in_use_imm;
      use_pc    <= in_use_pc;
      rd        <= in_rd;
      reg_write <= in_reg_write;
`ifdef ALU_ISSUE_SNOOP_EN
      rs1       <= in_rs1;
      rs2       <= in_rs2;
`endif
    end else if (valid && out_ready) begin
      valid <= 1'b0;
    end else if (valid) begin
`ifdef ALU_ISSUE_SNOOP_EN
      rs1_val <= hold_rs1_val;
      rs2_val <= hold_rs2_val;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= 16'h0000;
    else if (stall_inc && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end

  assign out_valid      = valid;
  assign out_alu_op     = alu_op;
  assign out_src_a      = use_pc ? pc : rs1_val;
  assign out_src_b      = use_imm ? imm : rs2_val;
  assign out_store_data = rs2_val;
  assign out_rd         = rd;
  assign out_reg_write  = reg_write;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed and randomized checks of alu_issue_stage against a queue model
// Honours ALU_ISSUE_SNOOP_EN the same way the design does.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_alu_op;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic        in_use_imm, in_use_pc, in_reg_write;
  logic        fwd_mem_valid, fwd_wb_valid;
  logic [4:0]  fwd_mem_rd, fwd_wb_rd;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [2:0]  out_alu_op;
  logic [31:0] out_src_a, out_src_b, out_store_data;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic [15:0] stall_cycles;

  alu_issue_stage #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_pc(in_pc), .in_use_imm(in_use_imm), .in_use_pc(in_use_pc),
    .in_rd(in_rd), .in_reg_write(in_reg_write),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
    .out_src_a(out_src_a), .out_src_b(out_src_b), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] a, b, imm, pc;
    logic        use_imm, use_pc, rw;
  } entry_t;

  entry_t mq[$];
  int     m_stall;
  int     checks = 0;
  int     errors = 0;
  int     nvalid;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_resolve(input logic [4:0] r, input logic [31:0] d);
    if (r == 0) return 32'h0;
    if (fwd_mem_valid && fwd_mem_rd == r) return fwd_mem_data;
    if (fwd_wb_valid && fwd_wb_rd == r) return fwd_wb_data;
    return d;
  endfunction

  task automatic idle();
    rst = 1'b0; in_valid = 1'b0; in_alu_op = 3'd0;
    in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0;
    in_rs1_data = 32'd0; in_rs2_data = 32'd0; in_imm = 32'd0; in_pc = 32'd0;
    in_use_imm = 1'b0; in_use_pc = 1'b0; in_reg_write = 1'b0;
    fwd_mem_valid = 1'b0; fwd_mem_rd = 5'd0; fwd_mem_data = 32'd0;
    fwd_wb_valid = 1'b0; fwd_wb_rd = 5'd0; fwd_wb_data = 32'd0;
    flush = 1'b0; out_ready = 1'b1;
  endtask

  task automatic compare_model();
    entry_t e;
    check("out_valid", out_valid, mq.size() != 0);
    check("in_ready", in_ready, (mq.size() == 0) || out_ready || flush || rst);
    check("stall_cycles", stall_cycles, m_stall);
    if (mq.size() != 0) begin
      e = mq[0];
      check("alu_op", out_alu_op, e.op);
      check("src_a", out_src_a, e.use_pc ? e.pc : e.a);
      check("src_b", out_src_b, e.use_imm ? e.imm : e.b);
      check("store_data", out_store_data, e.b);
      check("rd", out_rd, e.rd);
      check("reg_write", out_reg_write, e.rw);
    end
  endtask

  task automatic model_next();
    entry_t e;
    bit     accept;
    accept = in_valid && !flush && (mq.size() == 0 || out_ready);
    if (rst) begin
      mq.delete();
      m_stall = 0;
    end else begin
      if (mq.size() != 0 && !out_ready && !flush && m_stall < 65535) m_stall++;
      if (flush) begin
        mq.delete();
      end else if (mq.size() != 0 && !out_ready) begin
`ifdef ALU_ISSUE_SNOOP_EN
        e = mq[0];
        e.a = ref_resolve(e.rs1, e.a);
        e.b = ref_resolve(e.rs2, e.b);
        mq[0] = e;
`endif
      end else begin
        if (mq.size() != 0) void'(mq.pop_front());
        if (accept) begin
          e.op = in_alu_op; e.rs1 = in_rs1; e.rs2 = in_rs2; e.rd = in_rd;
          e.a = ref_resolve(in_rs1, in_rs1_data);
          e.b = ref_resolve(in_rs2, in_rs2_data);
          e.imm = in_imm; e.pc = in_pc; e.use_imm = in_use_imm; e.use_pc = in_use_pc;
          e.rw = in_reg_write;
          mq.push_back(e);
        end
      end
    end
  endtask

  // Inputs are set at the falling edge; checking happens 1 time unit later.
  task automatic cycle();
    #1;
    compare_model();
    model_next();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    mq.delete();
    m_stall = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_src_a", out_src_a, 0);
    check("rst_src_b", out_src_b, 0);
    check("rst_store", out_store_data, 0);
    check("rst_op_rd_rw", {out_alu_op, out_rd, out_reg_write}, 0);
    check("rst_stall", stall_cycles, 0);
    rst = 1'b0;

    // Simple immediate add, then drain
    in_valid = 1'b1; in_rs1 = 5'd1; in_rs1_data = 32'd5; in_use_imm = 1'b1; in_imm = 32'd7;
    cycle();
    idle();
    check("t1_valid", out_valid, 1);
    check("t1_src_a", out_src_a, 32'd5);
    check("t1_src_b", out_src_b, 32'd7);
    cycle();
    check("t1_drain", out_valid, 0);

    // Forwarding priority and the zero register
    in_valid = 1'b1; in_rs1 = 5'd3; in_rs1_data = 32'd1;
    fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'hAA;
    fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd3; fwd_wb_data = 32'hBB;
    cycle();
    check("t2_mem_prio", out_src_a, 32'hAA);
    in_rs1 = 5'd0; in_rs1_data = 32'd9; fwd_mem_rd = 5'd0; fwd_wb_rd = 5'd0;
    cycle();
    idle();
    check("t2_x0", out_src_a, 32'd0);
    cycle();

    // Stall for four cycles with a WB result for rs2 arriving in the second
    do_reset();
    in_valid = 1'b1; in_rs2 = 5'd2; in_rs2_data = 32'h55;
    cycle();
    idle();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fwd_wb_valid = (i == 1); fwd_wb_rd = 5'd2; fwd_wb_data = 32'h1234;
      cycle();
      if (i == 1) begin
`ifdef ALU_ISSUE_SNOOP_EN
        check("t3_snoop_b", out_src_b, 32'h1234);
        check("t3_snoop_st", out_store_data, 32'h1234);
`else
        check("t3_frozen_b", out_src_b, 32'h55);
`endif
      end
    end
    check("t3_stall4", stall_cycles, 16'd4);
    idle();
    cycle();

    // Stream eight back-to-back instructions
    do_reset();
    nvalid = 0;
    for (int i = 0; i < 9; i++) begin
      idle();
      in_valid = (i < 8);
      in_rs1 = 5'($urandom_range(0, 31)); in_rs1_data = $urandom;
      in_imm = $urandom; in_use_imm = 1'($urandom);
      #1 check("t4_in_ready", in_ready, 1);
      cycle();
      if (out_valid) nvalid++;
    end
    check("t4_count", nvalid, 8);
    check("t4_stall0", stall_cycles, 0);

    // Flush overrides a stalled entry and a simultaneous input
    do_reset();
    in_valid = 1'b1; in_rs1 = 5'd4; in_rs1_data = 32'h11;
    cycle();
    idle(); out_ready = 1'b0;
    cycle();
    flush = 1'b1; in_valid = 1'b1; in_rs1 = 5'd4; in_rs1_data = 32'h22;
    cycle();
    check("t5_flush_valid", out_valid, 0);
    check("t5_flush_stall", stall_cycles, 16'd1);
    idle();
    cycle();
    check("t5_not_captured", out_valid, 0);

    // Counter saturation, then reset clears it
    do_reset();
    in_valid = 1'b1;
    cycle();
    idle(); out_ready = 1'b0;
    for (int i = 0; i < 70000; i++) cycle();
    check("t6_saturate", stall_cycles, 16'hFFFF);
    do_reset();
    check("t6_rst_clear", stall_cycles, 16'h0000);

    // Randomized traffic with heavy register-index aliasing
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 255) == 0);
      in_valid      = ($urandom_range(0, 9) < 7);
      in_alu_op     = 3'($urandom);
      in_rs1        = 5'($urandom_range(0, 3));
      in_rs2        = 5'($urandom_range(0, 3));
      in_rd         = 5'($urandom);
      in_rs1_data   = $urandom;
      in_rs2_data   = $urandom;
      in_imm        = $urandom;
      in_pc         = $urandom;
      in_use_imm    = 1'($urandom);
      in_use_pc     = 1'($urandom);
      in_reg_write  = 1'($urandom);
      fwd_mem_valid = 1'($urandom);
      fwd_mem_rd    = 5'($urandom_range(0, 3));
      fwd_mem_data  = $urandom;
      fwd_wb_valid  = 1'($urandom);
      fwd_wb_rd     = 5'($urandom_range(0, 3));
      fwd_wb_data   = $urandom;
      flush         = ($urandom_range(0, 15) == 0);
      out_ready     = ($urandom_range(0, 9) < 6);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Single-entry issue register that sits directly upstream of the 32-bit ALU in the execute stage. Captures decoded operands and the 3-bit ALU opcode from decode, applies register forwarding from the memory and writeback stages, and presents `srcA`, `srcB` and `ALUControl`-ready values to the ALU behind a valid/ready handshake. While the entry is stalled, it refreshes held register operands from the forwarding buses so results are never stale.

## Interface
- `XLEN`, 32, datapath width.
- `RADDR_W`, 5, register-index width; index 0 is the hard-wired zero register.

- `clk` in 1: rising-edge clock; the block uses one clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: decode offers an instruction.
- `in_ready` out 1: stage accepts this cycle.
- `in_alu_op` in 3: ALU opcode, encoded 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 srl, 111 sra.
- `in_rs1`, `in_rs2` in RADDR_W: source indices.
- `in_rs1_data`, `in_rs2_data` in XLEN: register-file read data.
- `in_imm`, `in_pc` in XLEN: immediate and instruction PC.
- `in_use_imm` in 1: `src_b` = imm.
- `in_use_pc` in 1: `src_a` = pc.
- `in_rd` in RADDR_W, `in_reg_write` in 1: destination, passed through.
- `fwd_mem_valid` in 1, `fwd_mem_rd` in RADDR_W, `fwd_mem_data` in XLEN: EX/MEM result bus.
- `fwd_wb_valid` in 1, `fwd_wb_rd` in RADDR_W, `fwd_wb_data` in XLEN: MEM/WB result bus.
- `flush` in 1: kill the held entry and drop input.
- `out_valid` out 1, `out_ready` in 1: handshake to the ALU/EX stage.
- `out_alu_op` out 3, `out_src_a` out XLEN, `out_src_b` out XLEN: ALU operands.
- `out_store_data` out XLEN: resolved rs2 value (always register, never imm).
- `out_rd` out RADDR_W, `out_reg_write` out 1: passed-through destination.
- `stall_cycles` out 16: saturating count of stalled cycles.

## Operation
- Entry registers: valid, alu_op, rs1, rs2, rs1_val, rs2_val, imm, pc, use_imm, use_pc, rd, reg_write.
- Outputs:
  - `out_src_a` = use_pc ? pc : rs1_val.
  - `out_src_b` = use_imm ? imm : rs2_val.
  - `out_store_data` = rs2_val.
  - All are driven only from entry registers (no input-to-output combinational path except `in_ready`).
- `in_ready` = !out_valid | out_ready | flush.
- Forward resolve function for an index r and a default value d:
  - r==0 gives 0.
  - Otherwise, if fwd_mem_valid and fwd_mem_rd==r, give fwd_mem_data.
  - Otherwise, if fwd_wb_valid and fwd_wb_rd==r, give fwd_wb_data.
  - Otherwise give d. The MEM bus has priority because it carries the newer value.
- Capture happens when in_valid & in_ready & !flush:
  - rs1_val = resolve(in_rs1, in_rs1_data); rs2_val = resolve(in_rs2, in_rs2_data).
  - All other fields are copied; valid becomes 1.
- Hold happens when valid & !out_ready & !flush: rs1_val/rs2_val = resolve(rs, current value) (snoop refresh; see Configuration).
- Drain happens when valid & out_ready & !(in_valid) & !flush: valid becomes 0.
- Flush has priority over capture, hold and drain: valid becomes 0 next cycle; input is discarded even if in_valid.
- `stall_cycles` increments when out_valid & !out_ready & !flush, saturates at 0xFFFF, and is cleared only by rst.

## Timing
- Latency is 1 cycle from the accepted input to out_valid. Throughput is 1 instruction/cycle with out_ready held high.
- Back-to-back: on the same edge, the consumed entry is replaced by the new capture with no bubble.
- Reset values: out_valid 0, out_alu_op 000, out_src_a/out_src_b/out_store_data 0, out_rd 0, out_reg_write 0, stall_cycles 0. in_ready is 1 during and after reset.
- Reset mid-stall discards the entry. Flush and rst asserted together behave as rst.
- out_* are stable while out_valid & !out_ready, except rs-derived values that change by snoop refresh.

## Configuration
- `ALU_ISSUE_SNOOP_EN` defined: the hold-time refresh described above is active.
- `ALU_ISSUE_SNOOP_EN` undefined: operands are frozen at capture and the hold step does not modify rs1_val/rs2_val. In this mode the hazard unit must not let a producer retire past WB while a dependent instruction is stalled here. Capture-time forwarding is unchanged.

## Test plan
- Reset, then in_valid with alu_op=000, rs1_data=5, use_imm, imm=7, out_ready=1 -> one cycle later out_valid=1, src_a=5, src_b=7; following cycle out_valid=0.
- Capture rs1=3 with in_rs1_data=1, while fwd_mem(rd=3, 0xAA) and fwd_wb(rd=3, 0xBB) are both valid -> src_a=0xAA. With rs1=0 and a matching rd=0 bus -> src_a=0.
- Hold with out_ready=0 for 4 cycles, then fwd_wb(rd=rs2, 0x1234) in cycle 2 -> with SNOOP_EN, src_b and store_data become 0x1234 the next cycle; stall_cycles=4. Without SNOOP_EN, src_b stays unchanged.
- Stream 8 instructions with out_ready=1 -> 8 consecutive out_valid cycles, in_ready constant 1, stall_cycles=0.
- Stall an entry, then assert flush together with in_valid -> out_valid=0 next cycle, the input is not captured, and stall_cycles does not count the flush cycle.
- Hold out_ready=0 for 70000 cycles -> stall_cycles=0xFFFF and it does not wrap; rst then gives 0.
